// File: rtl/apb2wb_bridge.sv
// APB completer to Wishbone classic master bridge.
// One Wishbone single cycle per APB transfer, optional timeout.
module apb2wb_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_L =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_L);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    WB_REQ,
    RESP
  } state_t;

  state_t                state_q, state_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic                  err_q, err_n;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
  logic [ADDR_WIDTH-1:0] adr_q, adr_n;
  logic [DATA_WIDTH-1:0] dat_q, dat_n;
  logic                  we_q, we_n;
  logic                  apb_done;

  // State and captured transfer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
      rdata_q <= rdata_n;
      adr_q   <= adr_n;
      dat_q   <= dat_n;
      we_q    <= we_n;
    end
  end

  assign apb_done = (state_q == RESP) & PSEL & PENABLE;

  // Next-state, capture and Wishbone response handling.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    err_n   = err_q;
    rdata_n = rdata_q;
    adr_n   = adr_q;
    dat_n   = dat_q;
    we_n    = we_q;
    unique case (state_q)
      IDLE: begin
        if (PSEL) begin
          adr_n   = PADDR;
          dat_n   = PWDATA;
          we_n    = PWRITE;
          cnt_n   = '0;
          state_n = WB_REQ;
        end
      end
      WB_REQ: begin
        if (wb_err_i) begin
          err_n   = 1'b1;
          rdata_n = '0;
          state_n = RESP;
        end else if (wb_ack_i) begin
          err_n   = 1'b0;
          rdata_n = we_q ? '0 : wb_dat_i;
          state_n = RESP;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          err_n   = 1'b1;
          rdata_n = '0;
          state_n = RESP;
        end else if (cnt_q != '1) begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (apb_done || !PSEL) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus outputs decoded from registered state.
  always_comb begin
    wb_cyc_o = (state_q == WB_REQ);
    wb_stb_o = wb_cyc_o;
    wb_sel_o = {(DATA_WIDTH/8){wb_cyc_o}};
    wb_adr_o = adr_q;
    wb_dat_o = dat_q;
    wb_we_o  = we_q;
    PREADY   = apb_done;
    PSLVERR  = apb_done & err_q;
    PRDATA   = (apb_done && !PWRITE) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_apb2wb_bridge.sv
// Scoreboard bench for apb2wb_bridge.
// Directed APB transfers against a scripted Wishbone slave.
module tb_apb2wb_bridge;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] PADDR = '0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  apb2wb_bridge #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .PADDR(PADDR),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PWDATA(PWDATA),
    .PREADY(PREADY),
    .PRDATA(PRDATA),
    .PSLVERR(PSLVERR),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } apb_exp_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    int          len;
  } wb_exp_t;

  apb_exp_t apb_q[$];
  wb_exp_t  wb_q[$];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Slave behaviour knobs
  int          s_wait  = 0;
  bit          s_never = 1'b0;
  bit          s_ack   = 1'b1;
  bit          s_err   = 1'b0;
  logic [31:0] s_rdata = '0;
  int          scnt    = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scripted Wishbone slave: responds after s_wait stb cycles
  always @(posedge clk) begin
    #1;
    if (wb_stb_o) begin
      if (!s_never && scnt == s_wait) begin
        wb_ack_i = s_ack;
        wb_err_i = s_err;
        wb_dat_i = s_rdata;
      end else begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'hBAD0_BAD0;
      end
      scnt++;
    end else begin
      scnt = 0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
    end
  end

  // Monitor: pops expectations when the DUT presents responses
  bit      prev_stb = 1'b0;
  int      stb_len  = 0;
  wb_exp_t we_cur;
  apb_exp_t ae;

  always @(negedge clk) begin
    if (PREADY) begin
      if (apb_q.size() == 0) begin
        chk("pready_unexpected", 32'd1, 32'd0);
      end else begin
        ae = apb_q.pop_front();
        chk("prdata", PRDATA, ae.rd);
        chk("pslverr", {31'd0, PSLVERR}, {31'd0, ae.err});
      end
    end else begin
      chk("prdata_idle", PRDATA, 32'd0);
      chk("pslverr_idle", {31'd0, PSLVERR}, 32'd0);
    end
    if (wb_stb_o) begin
      if (wb_q.size() == 0) begin
        chk("stb_unexpected", 32'd1, 32'd0);
      end else begin
        we_cur = wb_q[0];
        chk("wb_adr", wb_adr_o, we_cur.adr);
        chk("wb_dat", wb_dat_o, we_cur.dat);
        chk("wb_we", {31'd0, wb_we_o}, {31'd0, we_cur.we});
        chk("wb_sel", {28'd0, wb_sel_o}, 32'hF);
        chk("wb_cyc", {31'd0, wb_cyc_o}, 32'd1);
      end
      stb_len++;
    end else if (prev_stb) begin
      if (wb_q.size() > 0) begin
        we_cur = wb_q.pop_front();
        if (we_cur.len != 0)
          chk("stb_len", stb_len, we_cur.len);
      end
      stb_len = 0;
    end
    prev_stb = wb_stb_o;
  end

  task automatic apb_xfer(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic        w,
                          input logic [31:0] exp_rd,
                          input logic        exp_err,
                          input int          exp_lat,
                          input int          exp_len,
                          input bit          scramble);
    int  t0;
    bit  got;
    apb_q.push_back('{rd: exp_rd, err: exp_err});
    wb_q.push_back('{adr: a, dat: d, we: w, len: exp_len});
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PADDR   = a;
    PWDATA  = d;
    PWRITE  = w;
    t0 = cyc;
    @(posedge clk);
    #1;
    PENABLE = 1'b1;
    if (scramble) begin
      PADDR  = ~a;
      PWDATA = ~d;
    end
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (PREADY) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("pready_timeout", 32'd0, 32'd1);
    end else if (exp_lat != 0) begin
      chk("latency", cyc - t0, exp_lat);
    end
    @(posedge clk);
    #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", {31'd0, PREADY}, 32'd0);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rst_we", {31'd0, wb_we_o}, 32'd0);
    chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait write
    s_wait = 0; s_never = 0; s_ack = 1; s_err = 0;
    s_rdata = 32'h5555_AAAA;
    apb_xfer(32'h10, 32'hDEAD_BEEF, 1'b1,
             32'h0, 1'b0, 2, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Read, three wait cycles, address/data scrambled after capture
    s_wait = 3; s_rdata = 32'h1234_5678;
    apb_xfer(32'h24, 32'h0BAD_F00D, 1'b0,
             32'h1234_5678, 1'b0, 5, 4, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Error and ack together: error wins
    s_wait = 0; s_err = 1; s_ack = 1;
    s_rdata = 32'hCAFE_CAFE;
    apb_xfer(32'h30, 32'h0, 1'b0,
             32'h0, 1'b1, 2, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Silent slave: timeout after four strobe cycles
    s_err = 0; s_never = 1;
    apb_xfer(32'h40, 32'h0, 1'b0,
             32'h0, 1'b1, 5, 4, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back writes
    s_never = 0; s_wait = 0; s_ack = 1;
    s_rdata = 32'h7777_7777;
    apb_xfer(32'h0, 32'h1, 1'b1,
             32'h0, 1'b0, 2, 1, 1'b0);
    apb_xfer(32'h4, 32'h2, 1'b1,
             32'h0, 1'b0, 2, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset while the Wishbone cycle is pending
    s_never = 1;
    wb_q.push_back('{adr: 32'h50, dat: 32'h99,
                     we: 1'b1, len: 0});
    PSEL = 1'b1; PENABLE = 1'b0;
    PADDR = 32'h50; PWDATA = 32'h99; PWRITE = 1'b1;
    @(posedge clk);
    #1;
    PENABLE = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    PSEL = 1'b0;
    PENABLE = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rstmid_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rstmid_pready", {31'd0, PREADY}, 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    s_never = 0; s_wait = 1;
    apb_xfer(32'h60, 32'hA5A5_0001, 1'b1,
             32'h0, 1'b0, 3, 2, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("apb_q_empty", apb_q.size(), 32'd0);
    chk("wb_q_empty", wb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
